// File: rtl/subterranean_pkg.sv
// Shared widths, defaults and sequencer state encoding for the Subterranean
// round sequencer and its serial/parallel state converter.
package subterranean_pkg;

  localparam int unsigned STATE_WIDTH        = 257;
  localparam int unsigned CNT_WIDTH          = 9;
  localparam int unsigned DEF_ROUNDS_WIDTH   = 4;
  localparam int unsigned DEF_FINISH_TIMEOUT = 8;

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(STATE_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UNLOAD = 3'd4,
    ST_RESP   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/subterranean_state_serdes.sv
// Parallel-in/serial-out load shifter and serial-in/parallel-out capture
// shifter sharing one bit counter; all enables come from the sequencer FSM.
module subterranean_state_serdes
  import subterranean_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [STATE_WIDTH-1:0] load_data,
  input  logic                   shift_en,
  input  logic                   cap_en,
  input  logic                   cap_clr,
  input  logic                   cnt_clr,
  input  logic                   serial_in,
  output logic                   serial_out,
  output logic [STATE_WIDTH-1:0] cap_data,
  output logic [CNT_WIDTH-1:0]   bit_cnt
);

  logic [STATE_WIDTH-1:0] ld_q, ld_d;
  logic [STATE_WIDTH-1:0] cap_q, cap_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  // Both shifters move right: bit 0 leaves first, captured bits enter at the MSB.
  always_comb begin
    ld_d  = ld_q;
    cap_d = cap_q;
    cnt_d = cnt_q;
    if (load_en) begin
      ld_d = load_data;
    end else if (shift_en) begin
      ld_d = {1'b0, ld_q[STATE_WIDTH-1:1]};
    end
    if (cap_clr) begin
      cap_d = '0;
    end else if (cap_en) begin
      cap_d = {serial_in, cap_q[STATE_WIDTH-1:1]};
    end
    if (cnt_clr || load_en) begin
      cnt_d = '0;
    end else if (shift_en || cap_en) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_q  <= '0;
      cap_q <= '0;
      cnt_q <= '0;
    end else begin
      ld_q  <= ld_d;
      cap_q <= cap_d;
      cnt_q <= cnt_d;
    end
  end

  assign serial_out = ld_q[0];
  assign cap_data   = cap_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: rtl/subterranean_round_sequencer.sv
// Drives a bit-serial Subterranean round core as a parallel multi-round
// permutation: serial load, R back-to-back rounds, serial unload, response.
module subterranean_round_sequencer
  import subterranean_pkg::*;
#(
  parameter int unsigned ROUNDS_WIDTH   = DEF_ROUNDS_WIDTH,
  parameter int unsigned FINISH_TIMEOUT = DEF_FINISH_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [STATE_WIDTH-1:0]  cmd_state,
  input  logic [ROUNDS_WIDTH-1:0] cmd_rounds,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [STATE_WIDTH-1:0]  rsp_state,
  output logic                    rsp_error,
  output logic                    core_start,
  input  logic                    core_finish,
  output logic                    core_data_in,
  output logic                    core_data_in_valid,
  input  logic                    core_data_in_ready,
  input  logic                    core_data_out,
  input  logic                    core_data_out_valid,
  output logic                    core_data_out_ready
);

  localparam int unsigned TO_WIDTH = $clog2(FINISH_TIMEOUT + 1);

  seq_state_e              state_q, state_d;
  logic [ROUNDS_WIDTH-1:0] rounds_q, rounds_d;
  logic [TO_WIDTH-1:0]     to_q, to_d;
  logic                    err_q, err_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    start_q, start_d;
  logic                    in_valid_q, in_valid_d;
  logic                    out_ready_q, out_ready_d;

  logic                    load_en, shift_en, cap_en, cap_clr, cnt_clr;
  logic [CNT_WIDTH-1:0]    bit_cnt;

  subterranean_state_serdes u_serdes (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_data (cmd_state),
    .shift_en  (shift_en),
    .cap_en    (cap_en),
    .cap_clr   (cap_clr),
    .cnt_clr   (cnt_clr),
    .serial_in (core_data_out),
    .serial_out(core_data_in),
    .cap_data  (rsp_state),
    .bit_cnt   (bit_cnt)
  );

  // Next state, round/timeout bookkeeping, and outputs decoded from the next state.
  always_comb begin
    state_d  = state_q;
    rounds_d = rounds_q;
    to_d     = to_q;
    err_d    = err_q;
    load_en  = 1'b0;
    shift_en = 1'b0;
    cap_en   = 1'b0;
    cap_clr  = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          load_en  = 1'b1;
          rounds_d = cmd_rounds;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (core_data_in_ready) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            cnt_clr = 1'b1;
            state_d = (rounds_q != '0) ? ST_START : ST_UNLOAD;
          end
        end
      end
      ST_START: begin
        to_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_finish) begin
          rounds_d = rounds_q - ROUNDS_WIDTH'(1);
          if (rounds_q == ROUNDS_WIDTH'(1)) begin
            cnt_clr = 1'b1;
            state_d = ST_UNLOAD;
          end else begin
            state_d = ST_START;
          end
        end else if (to_q == TO_WIDTH'(FINISH_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cap_clr = 1'b1;
          state_d = ST_RESP;
        end else begin
          to_d = to_q + TO_WIDTH'(1);
        end
      end
      ST_UNLOAD: begin
        if (core_data_out_valid) begin
          cap_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    start_d     = (state_d == ST_START);
    in_valid_d  = (state_d == ST_LOAD);
    out_ready_d = (state_d == ST_UNLOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rounds_q    <= '0;
      to_q        <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      start_q     <= 1'b0;
      in_valid_q  <= 1'b0;
      out_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rounds_q    <= rounds_d;
      to_q        <= to_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      start_q     <= start_d;
      in_valid_q  <= in_valid_d;
      out_ready_q <= out_ready_d;
    end
  end

  assign cmd_ready           = cmd_ready_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_error           = err_q;
  assign core_start          = start_q;
  assign core_data_in_valid  = in_valid_q;
  assign core_data_out_ready = out_ready_q;

endmodule
